// File: rtl/thresholds_axilite_loader.sv
// Streams N_WORDS K-bit threshold words into an AXI-lite slave starting at BASE_ADDR.
// Define THRESHOLDS_LOADER_READBACK_EN to read back and verify each word after it is written.
module thresholds_axilite_loader #(
    parameter int unsigned K         = 8,
    parameter int unsigned N_WORDS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [((K+7)/8)*8-1:0] s_axis_tdata,
    output logic                   m_axilite_AWVALID,
    input  logic                   m_axilite_AWREADY,
    output logic [ADDR_BITS-1:0]   m_axilite_AWADDR,
    output logic [2:0]             m_axilite_AWPROT,
    output logic                   m_axilite_WVALID,
    input  logic                   m_axilite_WREADY,
    output logic [31:0]            m_axilite_WDATA,
    output logic [3:0]             m_axilite_WSTRB,
    input  logic                   m_axilite_BVALID,
    output logic                   m_axilite_BREADY,
    input  logic [1:0]             m_axilite_BRESP,
    output logic                   m_axilite_ARVALID,
    input  logic                   m_axilite_ARREADY,
    output logic [ADDR_BITS-1:0]   m_axilite_ARADDR,
    output logic [2:0]             m_axilite_ARPROT,
    input  logic                   m_axilite_RVALID,
    output logic                   m_axilite_RREADY,
    input  logic [31:0]            m_axilite_RDATA,
    input  logic [1:0]             m_axilite_RRESP
);

    localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N_WORDS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StResp  = 3'd3;
    localparam logic [2:0] StRead  = 3'd4;
    localparam logic [2:0] StRdata = 3'd5;
    localparam logic [2:0] StFin   = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        index_q, index_d;
    logic                 err_q, err_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 aw_hs_q, aw_hs_d;
    logic                 w_hs_q, w_hs_d;
    logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [ADDR_BITS-1:0] word_addr;
    logic                 aw_fire, w_fire, advance;
`ifdef THRESHOLDS_LOADER_READBACK_EN
    logic                 arvalid_q, arvalid_d;
    logic [ADDR_BITS-1:0] araddr_q, araddr_d;
`endif

    assign word_addr = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'({index_q, 2'b00});
    assign aw_fire   = awvalid_q & m_axilite_AWREADY;
    assign w_fire    = wvalid_q & m_axilite_WREADY;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_hs_d   = aw_hs_q;
        w_hs_d    = w_hs_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        advance   = 1'b0;
`ifdef THRESHOLDS_LOADER_READBACK_EN
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    index_d = '0;
                    err_d   = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (s_axis_tvalid) begin
                    wdata_d   = 32'(s_axis_tdata[K-1:0]);
                    awaddr_d  = word_addr;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                // AW and W complete independently; leave once both have fired
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_hs_d   = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_hs_d   = 1'b1;
                end
                if ((aw_hs_q | aw_fire) && (w_hs_q | w_fire)) begin
                    aw_hs_d = 1'b0;
                    w_hs_d  = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (m_axilite_BVALID) begin
                    if (m_axilite_BRESP != 2'b00) err_d = 1'b1;
`ifdef THRESHOLDS_LOADER_READBACK_EN
                    arvalid_d = 1'b1;
                    araddr_d  = awaddr_q;
                    state_d   = StRead;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef THRESHOLDS_LOADER_READBACK_EN
            StRead: begin
                if (arvalid_q && m_axilite_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (m_axilite_RVALID) begin
                    if (m_axilite_RRESP != 2'b00 || m_axilite_RDATA[K-1:0] != wdata_q[K-1:0]) begin
                        err_d = 1'b1;
                    end
                    advance = 1'b1;
                end
            end
`else
            StRead, StRdata: state_d = StIdle;
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (index_q == LastIdx) begin
                state_d = StFin;
            end else begin
                index_d = index_q + IW'(1);
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            index_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_hs_q   <= 1'b0;
            w_hs_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_hs_q   <= aw_hs_d;
            w_hs_q    <= w_hs_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef THRESHOLDS_LOADER_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
        end
    end

    assign m_axilite_ARVALID = arvalid_q;
    assign m_axilite_ARADDR  = araddr_q;
    assign m_axilite_RREADY  = (state_q == StRdata);
`else
    assign m_axilite_ARVALID = 1'b0;
    assign m_axilite_ARADDR  = '0;
    assign m_axilite_RREADY  = 1'b0;
`endif

    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StFin);
    assign err               = err_q;
    assign s_axis_tready     = (state_q == StFetch);
    assign m_axilite_AWVALID = awvalid_q;
    assign m_axilite_AWADDR  = awaddr_q;
    assign m_axilite_AWPROT  = 3'b000;
    assign m_axilite_WVALID  = wvalid_q;
    assign m_axilite_WDATA   = wdata_q;
    assign m_axilite_WSTRB   = 4'hF;
    assign m_axilite_BREADY  = (state_q == StResp);
    assign m_axilite_ARPROT  = 3'b000;

    // Padding bits of the stream word and read-channel inputs in the write-only build
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tdata, m_axilite_ARREADY, m_axilite_RVALID,
                             m_axilite_RDATA, m_axilite_RRESP};

endmodule

// File: tb/tb_thresholds_axilite_loader.sv
// Directed bench for thresholds_axilite_loader: AXI-lite responder model plus write/read scoreboard.
// Honours THRESHOLDS_LOADER_READBACK_EN to exercise the readback path.
module tb_thresholds_axilite_loader;

    localparam int unsigned K         = 8;
    localparam int unsigned N_WORDS   = 4;
    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned BASE_ADDR = 32'h40;
`ifdef THRESHOLDS_LOADER_READBACK_EN
    localparam int unsigned PER_WORD = 5;
    localparam int unsigned RB       = 1;
`else
    localparam int unsigned PER_WORD = 3;
    localparam int unsigned RB       = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, err, s_axis_tready;
    logic s_axis_tvalid = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic [ADDR_BITS-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0] bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    thresholds_axilite_loader #(
        .K(K), .N_WORDS(N_WORDS), .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
        .m_axilite_AWPROT(awprot), .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready),
        .m_axilite_WDATA(wdata), .m_axilite_WSTRB(wstrb), .m_axilite_BVALID(bvalid),
        .m_axilite_BREADY(bready), .m_axilite_BRESP(bresp), .m_axilite_ARVALID(arvalid),
        .m_axilite_ARREADY(arready), .m_axilite_ARADDR(araddr), .m_axilite_ARPROT(arprot),
        .m_axilite_RVALID(rvalid), .m_axilite_RREADY(rready), .m_axilite_RDATA(rdata),
        .m_axilite_RRESP(rresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration, written only by the stimulus block while the DUT is idle
    int aw_delay = 0, w_delay = 0, bad_addr = -1, corrupt_addr = -1;

    // Responder state and monitors
    bit aw_got, w_got, aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_wait, w_wait;
    int aw_cnt, w_cnt, proto_err, aw_hi, w_hi, rr_hi, done_cnt;
    logic [15:0] got_addr, pend_addr, pend_araddr, prev_awaddr;
    logic [31:0] got_data, pend_data, prev_wdata;
    logic [31:0] mem [0:63];
    logic [47:0] obs_q[$], exp_q[$];
    logic [15:0] obs_rq[$], exp_rq[$];

    always @(posedge clk) begin
        #1;
        if (aw_pend) begin aw_got = 1'b1; got_addr = pend_addr; end
        if (w_pend) begin w_got = 1'b1; got_data = pend_data; end
        if (b_pend) bvalid = 1'b0;
        if (r_pend) rvalid = 1'b0;
        if (ar_pend) begin
            rvalid = 1'b1;
            rresp  = 2'b00;
            rdata  = (int'(pend_araddr) == corrupt_addr) ? 32'hFF : mem[pend_araddr[7:2]];
        end
        if (busy === 1'b1 && aw_wait && (!awvalid || awaddr != prev_awaddr)) proto_err++;
        if (busy === 1'b1 && w_wait && (!wvalid || wdata != prev_wdata)) proto_err++;
        if (bready === 1'b1 && !bvalid && !(aw_got && w_got)) proto_err++;
        if (busy !== 1'b1) begin
            aw_got = 1'b0; w_got = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        end
        if (aw_got && w_got) begin
            bvalid = 1'b1;
            bresp  = (int'(got_addr) == bad_addr) ? 2'b10 : 2'b00;
            mem[got_addr[7:2]] = got_data;
            obs_q.push_back({got_addr, got_data});
            aw_got = 1'b0; w_got = 1'b0;
        end
        if (awvalid === 1'b1) begin awready = (aw_cnt >= aw_delay); aw_cnt++; aw_hi++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid === 1'b1) begin wready = (w_cnt >= w_delay); w_cnt++; w_hi++; end
        else begin wready = 1'b0; w_cnt = 0; end
        arready = (arvalid === 1'b1);
        if (rready === 1'b1) rr_hi++;
        if (done === 1'b1) done_cnt++;
        aw_pend = (awvalid === 1'b1) && awready;  pend_addr = awaddr;
        w_pend  = (wvalid === 1'b1) && wready;    pend_data = wdata;
        b_pend  = bvalid && (bready === 1'b1);
        ar_pend = (arvalid === 1'b1) && arready;  pend_araddr = araddr;
        if (ar_pend) obs_rq.push_back(araddr);
        r_pend  = rvalid && (rready === 1'b1);
        aw_wait = (awvalid === 1'b1) && !awready; prev_awaddr = awaddr;
        w_wait  = (wvalid === 1'b1) && !wready;   prev_wdata = wdata;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain_scoreboard(input string tag);
        logic [47:0] o, e;
        logic [15:0] ro, re;
        check({tag, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, 64'(o), 64'(e));
        end
        check({tag, "_read_count"}, 64'(obs_rq.size()), 64'(exp_rq.size()));
        while (exp_rq.size() > 0 && obs_rq.size() > 0) begin
            ro = obs_rq.pop_front();
            re = exp_rq.pop_front();
            check({tag, "_read_addr"}, 64'(ro), 64'(re));
        end
        exp_q.delete(); obs_q.delete(); exp_rq.delete(); obs_rq.delete();
    endtask

    // One full load; `stall` idle FETCH cycles precede the first word, with a stray start pulse
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input logic [7:0] w3, input int stall, output int lat);
        logic [7:0] w [4];
        int t0, g, d0;
        bit hs, act, idle_seen;
        w = '{w0, w1, w2, w3};
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        act = 1'b0; idle_seen = 1'b0;
        for (int i = 0; i < stall; i++) begin
            start = (i == 4);
            tick();
            if (awvalid || wvalid || arvalid || bready || done) act = 1'b1;
            if (!busy) idle_seen = 1'b1;
        end
        start = 1'b0;
        if (stall > 0) begin
            check("stall_no_axi_valid", 64'(act), 64'd0);
            check("stall_busy_held", 64'(idle_seen), 64'd0);
        end
        for (int i = 0; i < N_WORDS; i++) begin
            s_axis_tdata  = w[i];
            s_axis_tvalid = 1'b1;
            exp_q.push_back({16'(BASE_ADDR + 4 * i), 32'(w[i])});
            if (RB != 0) exp_rq.push_back(16'(BASE_ADDR + 4 * i));
            hs = 1'b0; g = 0;
            while (!hs && g < 100) begin
                hs = s_axis_tready;
                tick();
                g++;
            end
            if (!hs) check("stream_handshake_timeout", 64'd0, 64'd1);
            s_axis_tvalid = 1'b0;
        end
        g = 0;
        while (!done && g < 200) begin tick(); g++; end
        check("done_seen", 64'(done), 64'd1);
        lat = cyc - t0;
        tick();
        check("done_single_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        tick();
        check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, a0, w0;
        bit act;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check("rst_awaddr", 64'(awaddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("const_wstrb", 64'(wstrb), 64'hF);
        check("const_prot", 64'({awprot, arprot}), 64'd0);

        // Zero-wait load
        run_load(8'h11, 8'h22, 8'h33, 8'h44, 0, lat);
        check("zw_latency", 64'(lat), 64'(N_WORDS * PER_WORD));
        check("zw_err", 64'(err), 64'd0);
        drain_scoreboard("zw");

        // Delayed AWREADY, immediate WREADY
        aw_delay = 3;
        a0 = aw_hi; w0 = w_hi;
        run_load(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, lat);
        check("awdly_wvalid_cycles", 64'(w_hi - w0), 64'(N_WORDS));
        check("awdly_awvalid_cycles", 64'(aw_hi - a0), 64'(N_WORDS * 4));
        check("awdly_err", 64'(err), 64'd0);
        drain_scoreboard("awdly");
        aw_delay = 0;

        // SLVERR on the second word
        bad_addr = int'(BASE_ADDR + 4);
        run_load(8'h05, 8'h06, 8'h07, 8'h08, 0, lat);
        check("bresp_err_sticky", 64'(err), 64'd1);
        drain_scoreboard("bresp");
        bad_addr = -1;

        // Stream stall with a start pulse while busy; err must clear on the new start
        run_load(8'h21, 8'h32, 8'h43, 8'h54, 10, lat);
        check("stall_latency", 64'(lat), 64'(N_WORDS * PER_WORD + 10));
        check("stall_err_cleared", 64'(err), 64'd0);
        drain_scoreboard("stall");

        // Reset while AWVALID waits for AWREADY
        aw_delay = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_axis_tdata  = 8'h55;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        check("midrst_awvalid_waiting", 64'(awvalid), 64'd1);
        check("midrst_wvalid_dropped", 64'(wvalid), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_awvalid", 64'(awvalid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_awaddr", 64'(awaddr), 64'd0);
        act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (awvalid || wvalid || arvalid || bready || rready || busy) act = 1'b1;
        end
        check("midrst_quiet", 64'(act), 64'd0);
        check("midrst_no_write", 64'(obs_q.size()), 64'd0);
        aw_delay = 0;
        run_load(8'h61, 8'h62, 8'h63, 8'h64, 0, lat);
        check("reload_err", 64'(err), 64'd0);
        drain_scoreboard("reload");

`ifdef THRESHOLDS_LOADER_READBACK_EN
        // Readback returns 0xFF for a written 0x7F
        corrupt_addr = int'(BASE_ADDR + 8);
        run_load(8'h01, 8'h02, 8'h7F, 8'h04, 0, lat);
        check("rb_bad_err", 64'(err), 64'd1);
        drain_scoreboard("rb_bad");
        corrupt_addr = -1;
        run_load(8'h01, 8'h02, 8'h7F, 8'h04, 0, lat);
        check("rb_good_err", 64'(err), 64'd0);
        check("rb_latency", 64'(lat), 64'(N_WORDS * PER_WORD));
        drain_scoreboard("rb_good");
`else
        check("no_rb_rready_cycles", 64'(rr_hi), 64'd0);
`endif
        check("protocol_violations", 64'(proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
